// File: rtl/program_loader.sv
// program_loader: streams handshaked instructions into sequential memory locations
module program_loader #(
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_opcode,
  input  logic [AW-1:0] in_addr,
  input  logic          in_last,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [AW+2:0] mdat,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   count,
  output logic          full
);
  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;
  state_t state;
  logic   last_q;
  assign in_ready = state == LOAD;
  assign mem_we   = state == WRITE;
  assign busy     = state != IDLE;
  assign done     = state == DONE;
  assign full     = count[AW];
  // count doubles as the write pointer; it never wraps because the top location forces DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      mem_addr <= '0;
      mdat     <= '0;
      last_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= LOAD;
          count <= '0;
        end
        LOAD: if (in_valid) begin
          state    <= WRITE;
          mdat     <= {in_opcode, in_addr};
          mem_addr <= count[AW-1:0];
          last_q   <= in_last;
        end
        WRITE: begin
          count <= count + 1'b1;
          state <= (last_q || &count[AW-1:0]) ? DONE : LOAD;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed self-checking bench for program_loader
module tb_program_loader;
  localparam int AW = 5;
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_opcode = '0;
  logic [AW-1:0] in_addr = '0;
  logic          in_last = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [AW+2:0] mdat;
  logic          busy;
  logic          done;
  logic [AW:0]   count;
  logic          full;
  int errors = 0;
  int checks = 0;
  int nw = 0;
  int nd = 0;
  logic [AW-1:0] wa [0:255];
  logic [AW+2:0] wd [0:255];

  program_loader #(.AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_addr(in_addr), .in_last(in_last), .mem_we(mem_we),
    .mem_addr(mem_addr), .mdat(mdat), .busy(busy), .done(done), .count(count), .full(full)
  );

  always #5 clk = ~clk;

  // log every write and done pulse seen mid-cycle
  always @(negedge clk) begin
    if (mem_we && nw < 256) begin
      wa[nw] = mem_addr;
      wd[nw] = mdat;
      nw++;
    end
    if (done) nd++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [2:0] op, input logic [AW-1:0] a, input logic l, input int bound, output logic ok);
    in_valid = 1'b1; in_opcode = op; in_addr = a; in_last = l; ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      ok = in_ready;
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; in_valid = 1'b1;
    tick(); tick();
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    checks++;
    if ({in_ready, mem_we, mem_addr, mdat, busy, done, count, full} !== '0) begin
      errors++;
      $display("FAIL reset: rdy=%b we=%b addr=%0d mdat=%h busy=%b done=%b count=%0d full=%b, all required 0",
               in_ready, mem_we, mem_addr, mdat, busy, done, count, full);
    end
  endtask

  task automatic test_three_word();
    int b;
    logic ok;
    b = nw;
    in_valid = 1'b1; in_opcode = 3'b101; in_addr = 5'd7;
    do_start();
    checks++;
    if (in_ready !== 1'b1 || mem_we !== 1'b0 || nw != b) begin
      errors++;
      $display("FAIL start_with_valid: rdy=%b we=%b writes=%0d, required rdy=1 we=0 writes=0", in_ready, mem_we, nw - b);
    end
    send(3'b101, 5'd7, 1'b0, 20, ok);
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 5'd0 || mdat !== 8'hA7) begin
      errors++;
      $display("FAIL latency: we=%b addr=%0d mdat=%h, required 1/0/a7", mem_we, mem_addr, mdat);
    end
    send(3'b010, 5'd31, 1'b0, 20, ok);
    send(3'b111, 5'd0, 1'b1, 20, ok);
    tick();
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL three_done: done=%b busy=%b rdy=%b we=%b, required 1/1/0/0", done, busy, in_ready, mem_we);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || count !== 6'd3 || full !== 1'b0 || mem_addr !== 5'd2 || mdat !== 8'hE0) begin
      errors++;
      $display("FAIL three_end: done=%b busy=%b count=%0d full=%b addr=%0d mdat=%h, required 0/0/3/0/2/e0",
               done, busy, count, full, mem_addr, mdat);
    end
    checks++;
    if (nw - b != 3 || wa[b] !== 5'd0 || wd[b] !== 8'hA7 || wa[b+1] !== 5'd1 || wd[b+1] !== 8'h5F ||
        wa[b+2] !== 5'd2 || wd[b+2] !== 8'hE0) begin
      errors++;
      $display("FAIL three_writes: n=%0d %h@%0d %h@%0d %h@%0d, required 3 a7@0 5f@1 e0@2",
               nw - b, wd[b], wa[b], wd[b+1], wa[b+1], wd[b+2], wa[b+2]);
    end
    tick(); tick();
    checks++;
    if (count !== 6'd3 || nd != 1) begin
      errors++;
      $display("FAIL count_hold: count=%0d dones=%0d, required 3 and 1", count, nd);
    end
  endtask

  task automatic test_backpressure();
    int b;
    int bad;
    logic ok;
    b = nw; bad = 0;
    do_start();
    for (int i = 0; i < 5; i++) begin
      if (in_ready !== 1'b1 || mem_we !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0 || nw != b) begin
      errors++;
      $display("FAIL backpressure_idle: bad_cycles=%0d writes=%0d, required 0 and 0", bad, nw - b);
    end
    send(3'b011, 5'd9, 1'b1, 20, ok);
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 5'd0 || mdat !== 8'h69) begin
      errors++;
      $display("FAIL backpressure_write: we=%b addr=%0d mdat=%h, required 1/0/69", mem_we, mem_addr, mdat);
    end
    tick();
    checks++;
    if (mem_we !== 1'b0 || nw - b != 1) begin
      errors++;
      $display("FAIL backpressure_single: we=%b writes=%0d, required 0 and 1", mem_we, nw - b);
    end
    tick();
  endtask

  task automatic test_full();
    int b;
    int bad;
    logic ok;
    b = nw; bad = 0;
    do_start();
    for (int i = 0; i < 32; i++) begin
      send(3'(i), 5'(i) ^ 5'h15, 1'b0, 20, ok);
      if (!ok) bad++;
    end
    checks++;
    if (bad != 0 || mem_addr !== 5'd31) begin
      errors++;
      $display("FAIL full_accept: rejected=%0d addr=%0d, required 0 and 31", bad, mem_addr);
    end
    tick();
    checks++;
    if (done !== 1'b1 || full !== 1'b1 || count !== 6'd32 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_done: done=%b full=%b count=%0d rdy=%b, required 1/1/32/0", done, full, count, in_ready);
    end
    send(3'b110, 5'd3, 1'b0, 12, ok);
    checks++;
    if (ok !== 1'b0 || full !== 1'b1 || count !== 6'd32 || nw - b != 32) begin
      errors++;
      $display("FAIL full_word33: accepted=%b full=%b count=%0d writes=%0d, required 0/1/32/32", ok, full, count, nw - b);
    end
    bad = 0;
    for (int i = 0; i < 32; i++)
      if (wa[b+i] !== 5'(i) || wd[b+i] !== {3'(i), 5'(i) ^ 5'h15}) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL full_writes: wrong entries=%0d, required 0", bad);
    end
  endtask

  task automatic test_abort();
    int b;
    int d0;
    logic ok;
    b = nw;
    do_start();
    send(3'b001, 5'd4, 1'b0, 20, ok);
    send(3'b010, 5'd5, 1'b0, 20, ok);
    d0 = nd;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (mem_we !== 1'b0 || busy !== 1'b0 || count !== 6'd0 || full !== 1'b0 || nd != d0 || nw - b != 2) begin
      errors++;
      $display("FAIL abort: we=%b busy=%b count=%0d full=%b dones=%0d writes=%0d, required 0/0/0/0/0/2",
               mem_we, busy, count, full, nd - d0, nw - b);
    end
    do_start();
    send(3'b100, 5'd1, 1'b1, 20, ok);
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 5'd0 || mdat !== 8'h81) begin
      errors++;
      $display("FAIL abort_restart: we=%b addr=%0d mdat=%h, required 1/0/81", mem_we, mem_addr, mdat);
    end
    tick(); tick();
  endtask

  task automatic test_ignored_start();
    int b;
    logic ok;
    b = nw;
    do_start();
    send(3'b000, 5'd10, 1'b0, 20, ok);
    start = 1'b1;
    tick(); tick();
    start = 1'b0;
    checks++;
    if (count !== 6'd1 || in_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL ignored_start: count=%0d rdy=%b busy=%b, required 1/1/1", count, in_ready, busy);
    end
    start = 1'b1;
    send(3'b001, 5'd11, 1'b0, 20, ok);
    send(3'b010, 5'd12, 1'b1, 20, ok);
    start = 1'b0;
    tick(); tick();
    checks++;
    if (count !== 6'd3 || nw - b != 3 || wa[b+1] !== 5'd1 || wa[b+2] !== 5'd2 || wd[b+2] !== 8'h4C) begin
      errors++;
      $display("FAIL ignored_start_seq: count=%0d writes=%0d addr1=%0d addr2=%0d mdat2=%h, required 3/3/1/2/4c",
               count, nw - b, wa[b+1], wa[b+2], wd[b+2]);
    end
  endtask

  initial begin
    test_reset();
    test_three_word();
    test_backpressure();
    test_full();
    test_abort();
    test_ignored_start();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
